// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Shared Hamming width derivation and position-mapping helpers
// Purpose : parity-width calculation, Hamming position -> data index mapping and
//           codeword width derivation, shared by the encoder and the matching decoder.
// Macro   : HAMMING_SECDED_EN adds one overall-parity bit to the codeword width.
package hamming_pkg;

    // Smallest R with 2^R >= data_w + R + 1.
    function automatic int calc_par_w(input int data_w);
        int r;
        r = 1;
        for (int i = 0; i < 8; i++) begin
            if ((1 << r) < data_w + r + 1) r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Data index carried at 1-based Hamming position pos; -1 for parity positions.
    function automatic int data_index(input int pos);
        int idx;
        idx = 0;
        if (is_pow2(pos)) return -1;
        for (int p = 1; p < pos; p++) begin
            if (!is_pow2(p)) idx = idx + 1;
        end
        return idx;
    endfunction

    function automatic int calc_cw_w(input int data_w);
`ifdef HAMMING_SECDED_EN
        return data_w + calc_par_w(data_w) + 1;
`else
        return data_w + calc_par_w(data_w);
`endif
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// rtl/hamming_parity_gen.sv - Combinational Hamming codeword generator
// Purpose : maps data_i onto non-power-of-two positions and computes the parity bits.
// Ports   : data_i     - data word (DATA_W bits)
//           codeword_o - codeword, bit k = Hamming position k+1 (CW_W bits)
// Macro   : HAMMING_SECDED_EN appends an overall even-parity bit as the MSB.
module hamming_parity_gen
    import hamming_pkg::*;
#(
    parameter int  DATA_W = 4,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CW_W   = calc_cw_w(DATA_W)
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CW_W-1:0]   codeword_o
);

    localparam int HC_W = DATA_W + PAR_W;

    // Data bits covered by parity bit i: those whose position has bit i set.
    function automatic logic [DATA_W-1:0] cover_mask(input int bit_i);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int p = 1; p <= HC_W; p++) begin
            if (!is_pow2(p) && (((p >> bit_i) & 1) != 0))
                m = m | ({{(DATA_W-1){1'b0}}, 1'b1} << data_index(p));
        end
        return m;
    endfunction

    logic [PAR_W-1:0] par;
    logic [HC_W-1:0]  hc;

    for (genvar i = 0; i < PAR_W; i++) begin : g_par
        localparam logic [DATA_W-1:0] MASK = cover_mask(i);
        assign par[i] = ^(data_i & MASK);
    end

    for (genvar p = 1; p <= HC_W; p++) begin : g_pos
        localparam int DI = data_index(p);
        if (DI < 0) begin : g_parity
            assign hc[p-1] = par[$clog2(p)];
        end else begin : g_data
            assign hc[p-1] = data_i[DI];
        end
    end

`ifdef HAMMING_SECDED_EN
    assign codeword_o = {^hc, hc};
`else
    assign codeword_o = hc;
`endif

endmodule

// File: rtl/hamming_stream_encoder.sv
// rtl/hamming_stream_encoder.sv - Streaming Hamming encoder with skid buffer and word counter
// Purpose : accepts data words over a valid/ready handshake, encodes them and presents
//           codewords one cycle later through a main + skid output stage.
// Ports   : clk, rst_n (async, active-low), enable (input gate),
//           in_valid/in_ready/in_data    - upstream word handshake
//           out_valid/out_ready/out_data - downstream codeword handshake
//           count_clear/word_count       - saturating accepted-word counter
// Macro   : HAMMING_SECDED_EN widens out_data by one overall-parity bit.
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter int  DATA_W = 4,
    parameter int  CNT_W  = 16,
    localparam int CW_W   = calc_cw_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW_W-1:0]   out_data,
    input  logic              count_clear,
    output logic [CNT_W-1:0]  word_count
);

    logic [CW_W-1:0]  enc_cw;
    logic             run_q;
    logic             main_valid_q, main_valid_d;
    logic [CW_W-1:0]  main_data_q, main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CW_W-1:0]  skid_data_q, skid_data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             accept;
    logic             consume;

    hamming_parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
        .data_i     (in_data),
        .codeword_o (enc_cw)
    );

    // run_q keeps in_ready low until the first clock edge after reset release.
    // in_ready depends only on registered state, never on out_ready.
    assign in_ready   = enable & run_q & ~skid_valid_q;
    assign accept     = in_valid & in_ready;
    assign out_valid  = main_valid_q;
    assign out_data   = main_data_q;
    assign consume    = main_valid_q & out_ready;
    assign word_count = count_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (consume) begin
            if (skid_valid_q) begin
                // Skid full means no accept this cycle; promote the older word.
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = enc_cw;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = enc_cw;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = enc_cw;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (count_clear) begin
            count_d = '0;
        end else if (accept && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            count_q      <= '0;
        end else begin
            run_q        <= 1'b1;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// tb/tb_hamming_stream_encoder.sv - Scoreboard testbench for hamming_stream_encoder
module tb_hamming_stream_encoder;

    localparam int DATA_W  = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAMMING_SECDED_EN
    localparam int CW_W = 8;
    localparam logic [CW_W-1:0] KAT_0001 = 8'h87;
    localparam logic [CW_W-1:0] KAT_1011 = 8'h55;
`else
    localparam int CW_W = 7;
    localparam logic [CW_W-1:0] KAT_0001 = 7'h07;
    localparam logic [CW_W-1:0] KAT_1011 = 7'h55;
`endif

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW_W-1:0]   out_data;
    logic              count_clear;
    logic [CNT_W-1:0]  word_count;

    hamming_stream_encoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count_clear (count_clear),
        .word_count  (word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    logic [7:0]        exp_q[$];
    int                count_m     = 0;
    bit                run_m       = 1'b0;
    bit                acc_pending = 1'b0;
    bit                clr_pending = 1'b0;
    logic [DATA_W-1:0] d_pending   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity bits equal the XOR of the positions of all set data bits.
    function automatic logic [7:0] ref_encode(input logic [3:0] d);
        logic [7:0] cw;
        logic [7:0] syn;
        int di;
        cw  = '0;
        syn = '0;
        di  = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[di]) begin
                    cw[pos-1] = 1'b1;
                    syn       = syn ^ 8'(pos);
                end
                di++;
            end
        end
        cw[0] = syn[0];
        cw[1] = syn[1];
        cw[3] = syn[2];
`ifdef HAMMING_SECDED_EN
        cw[7] = ^cw[6:0];
`endif
        return cw;
    endfunction

    // One clock cycle of stimulus; the word the DUT took at the last edge is
    // pushed to the scoreboard, then the new inputs are applied.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic en,
                        input logic ordy, input logic clr);
        bit exp_rdy;
        @(posedge clk);
        #1;
        if (rst_n) run_m = 1'b1;
        if (clr_pending) count_m = 0;
        else if (acc_pending && count_m < CNT_MAX) count_m++;
        if (acc_pending) exp_q.push_back(ref_encode(d_pending));
        in_valid    = v;
        in_data     = d;
        enable      = en;
        out_ready   = ordy;
        count_clear = clr;
        #3;
        exp_rdy = run_m && en && (exp_q.size() < 2);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc_pending = v && exp_rdy;
        clr_pending = clr;
        d_pending   = d;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        enable      = 1'b0;
        out_ready   = 1'b0;
        count_clear = 1'b0;
        exp_q.delete();
        count_m     = 0;
        run_m       = 1'b0;
        acc_pending = 1'b0;
        clr_pending = 1'b0;
        #1;
        check("reset_async_out_valid", 32'(out_valid), 32'd0);
        check("reset_async_word_count", 32'(word_count), 32'd0);
        check("reset_async_in_ready", 32'(in_ready), 32'd0);
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_out_data", 32'(out_data), 32'd0);
                check("rst_in_ready", 32'(in_ready), 32'd0);
                check("rst_word_count", 32'(word_count), 32'd0);
            end else begin
                check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
                check("word_count", 32'(word_count), 32'(count_m));
                if (out_valid && exp_q.size() > 0) begin
                    check("out_data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : driver
        rst_n       = 1'b0;
        enable      = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        count_clear = 1'b0;
        do_reset(3);

        // Known-answer vectors with one-cycle latency
        step(1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        check("kat_1011_valid", 32'(out_valid), 32'd1);
        check("kat_1011_data", 32'(out_data), 32'(KAT_1011));
        drain(2);
        step(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        check("kat_0001_data", 32'(out_data), 32'(KAT_0001));
        drain(2);

        // Backpressure: third word stalls until out_ready returns
        step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'hC, 1'b1, 1'b1, 1'b0);
        drain(4);

        // enable low with two words buffered: drain continues, no acceptance
        step(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
        check("en_off_drained", 32'(out_valid), 32'd0);

        // Counter saturation and clear priority
        do_reset(2);
        for (int i = 0; i < 20; i++) step(1'b1, 4'(i), 1'b1, 1'b1, 1'b0);
        drain(2);
        check("count_saturated", 32'(word_count), 32'(CNT_MAX));
        step(1'b1, 4'h6, 1'b1, 1'b1, 1'b1);
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check("count_clear_priority", 32'(word_count), 32'd0);
        drain(2);

        // Reset with two words buffered: nothing stale afterwards
        step(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 4'hE, 1'b1, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        do_reset(2);
        drain(3);
        check("post_reset_no_stale", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        drain(6);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
